// File: rtl/axis_dwc_down.sv
// rtl/axis_dwc_down.sv - AXI-Stream width down-converter, one wide beat serialised into RATIO narrow words.
// Define AXIS_DWC_MSB_FIRST_EN to emit the most significant sub-word first (default is LSB-first).
module axis_dwc_down #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_areset,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_word_count
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IN_WIDTH-1:0]    hold_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [IDX_W-1:0]       sel;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   load;
    logic                   last;
    logic                   out_hs;
    logic [OUT_WIDTH-1:0]   words [RATIO];

    assign last          = (idx_q == LAST_IDX);
    assign m_axis_tvalid = (state_q == SHIFT);
    assign out_hs        = m_axis_tvalid & m_axis_tready;
    assign o_busy        = (state_q == SHIFT);
    assign o_word_count  = cnt_q;

    for (genvar i = 0; i < RATIO; i++) begin : g_slice
        assign words[i] = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
    end

`ifdef AXIS_DWC_MSB_FIRST_EN
    assign sel = LAST_IDX - idx_q;
`else
    assign sel = idx_q;
`endif

    assign m_axis_tdata = words[sel];

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready opens on the final sub-word handoff so the next beat loads with no bubble.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        load          = 1'b0;
        s_axis_tready = 1'b0;
        case (state_q)
            IDLE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (m_axis_tready) begin
                    if (!last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        s_axis_tready = 1'b1;
                        idx_d         = '0;
                        if (s_axis_tvalid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else begin
            idx_q <= idx_d;
            if (load) begin
                hold_q <= s_axis_tdata;
            end
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            cnt_q <= '0;
        end else if (out_hs) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_dwc_down.sv
// tb/tb_axis_dwc_down.sv - directed self-checking bench for axis_dwc_down (both word-order builds).
module tb_axis_dwc_down;

    logic        clk = 1'b0;
    logic        areset;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        busy;
    logic [31:0] count;
    logic        s_tready4;
    logic [15:0] m_tdata4;
    logic        m_tvalid4;
    logic        busy4;
    logic [3:0]  count4;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    axis_dwc_down #(.IN_WIDTH(64), .OUT_WIDTH(16), .CNT_WIDTH(32)) dut (
        .m_axi_aclk    (clk),
        .m_axi_areset  (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .o_busy        (busy),
        .o_word_count  (count)
    );

    axis_dwc_down #(.IN_WIDTH(64), .OUT_WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .m_axi_aclk    (clk),
        .m_axi_areset  (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready4),
        .m_axis_tdata  (m_tdata4),
        .m_axis_tvalid (m_tvalid4),
        .m_axis_tready (m_tready),
        .o_busy        (busy4),
        .o_word_count  (count4)
    );

    function automatic logic [15:0] exp_word(input logic [63:0] beat, input int k);
        int j;
`ifdef AXIS_DWC_MSB_FIRST_EN
        j = 3 - k;
`else
        j = k;
`endif
        return beat[j*16 +: 16];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        areset = 1'b0;
    endtask

    localparam logic [63:0] BEAT1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] BEAT_A = 64'h00A3_00A2_00A1_00A0;
    localparam logic [63:0] BEAT_B = 64'h00B3_00B2_00B1_00B0;
    localparam logic [63:0] BEAT_S = 64'h0003_0002_0001_0000;
    localparam logic [63:0] BEAT_C = 64'h00C3_00C2_00C1_00C0;

    initial begin
        areset   = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        step();
        step();

        // reset state
        check("rst_s_tready", 64'(s_tready), 64'd1);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        areset = 1'b0;

        // single beat
        s_tdata  = BEAT1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        check("single_idle_ready", 64'(s_tready), 64'd1);
        step();
        s_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("single_tvalid", 64'(m_tvalid), 64'd1);
            check("single_word", 64'(m_tdata), 64'(exp_word(BEAT1, k)));
            check("single_count", 64'(count), 64'(k));
            if (k == 3) check("single_last_ready", 64'(s_tready), 64'd1);
            else        check("single_mid_ready", 64'(s_tready), 64'd0);
            step();
        end
        check("single_done_tvalid", 64'(m_tvalid), 64'd0);
        check("single_done_busy", 64'(busy), 64'd0);
        check("single_done_count", 64'(count), 64'd4);

        // back-to-back beats, no bubble
        s_tdata  = BEAT_A;
        s_tvalid = 1'b1;
        step();
        s_tdata = BEAT_B;
        for (int k = 0; k < 4; k++) begin
            check("b2b_a_tvalid", 64'(m_tvalid), 64'd1);
            check("b2b_a_word", 64'(m_tdata), 64'(exp_word(BEAT_A, k)));
            if (k == 3) check("b2b_a3_ready", 64'(s_tready), 64'd1);
            step();
        end
        s_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("b2b_b_tvalid", 64'(m_tvalid), 64'd1);
            check("b2b_b_word", 64'(m_tdata), 64'(exp_word(BEAT_B, k)));
            step();
        end
        check("b2b_done_tvalid", 64'(m_tvalid), 64'd0);
        check("b2b_count", 64'(count), 64'd12);

        // downstream stall after two handoffs
        do_reset();
        s_tdata  = BEAT_S;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        step();
        step();
        m_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("stall_tvalid", 64'(m_tvalid), 64'd1);
            check("stall_word", 64'(m_tdata), 64'(exp_word(BEAT_S, 2)));
            check("stall_s_tready", 64'(s_tready), 64'd0);
            check("stall_count", 64'(count), 64'd2);
            step();
        end
        m_tready = 1'b1;
        check("resume_word2", 64'(m_tdata), 64'(exp_word(BEAT_S, 2)));
        step();
        check("resume_word3", 64'(m_tdata), 64'(exp_word(BEAT_S, 3)));
        step();
        check("stall_done_count", 64'(count), 64'd4);
        check("stall_done_tvalid", 64'(m_tvalid), 64'd0);

        // reset mid-beat, colliding with an input and output handshake
        s_tdata  = BEAT1;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        step();
        step();
        check("premid_count", 64'(count), 64'd6);
        areset   = 1'b1;
        s_tdata  = BEAT_A;
        s_tvalid = 1'b1;
        step();
        areset   = 1'b0;
        s_tvalid = 1'b0;
        check("midrst_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_s_tready", 64'(s_tready), 64'd1);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        s_tdata  = BEAT_C;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("post_rst_word", 64'(m_tdata), 64'(exp_word(BEAT_C, k)));
            step();
        end
        check("post_rst_count", 64'(count), 64'd4);

        // counter wrap on the 4-bit instance
        do_reset();
        for (int b = 0; b < 5; b++) begin
            s_tdata  = BEAT_A;
            s_tvalid = 1'b1;
            step();
            s_tvalid = 1'b0;
            for (int k = 0; k < 4; k++) step();
        end
        check("wrap_count4", 64'(count4), 64'd4);
        check("wrap_count32", 64'(count), 64'd20);
        check("wrap_tvalid4", 64'(m_tvalid4), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/axis_dwc_down.md
# axis_dwc_down

Downstream AXI-Stream width down-converter that consumes wide beats from the 64-bit AXIS FIFO output and serialises each beat into RATIO = IN_WIDTH/OUT_WIDTH narrow words for the 16-bit processing datapath. It holds one wide beat in a register and walks a sub-word index. It accepts the next beat in the same cycle the last sub-word is handed off, so it sustains one narrow word per cycle with no bubble. It also reports a running count of emitted words for status and debug.

## Interface

Parameters:
- IN_WIDTH, default 64, width of the slave (wide) data bus.
- OUT_WIDTH, default 16, width of the master (narrow) data bus. IN_WIDTH must be an integer multiple of OUT_WIDTH, with RATIO ≥ 2.
- CNT_WIDTH, default 32, width of the emitted-word counter.

Ports:
- m_axi_aclk, in, 1, the single clock. All logic is rising-edge.
- m_axi_areset, in, 1, synchronous active-high reset, sampled on the rising edge of m_axi_aclk.
- s_axis_tdata, in, IN_WIDTH, wide input beat.
- s_axis_tvalid, in, 1, input beat valid.
- s_axis_tready, out, 1, converter can take a beat this cycle.
- m_axis_tdata, out, OUT_WIDTH, current narrow word.
- m_axis_tvalid, out, 1, narrow word valid.
- m_axis_tready, in, 1, downstream accepts the narrow word.
- o_busy, out, 1, a beat is held (state SHIFT).
- o_word_count, out, CNT_WIDTH, number of narrow handshakes completed since reset.

## Operation

- Registers:
  - hold_q[IN_WIDTH-1:0]
  - idx_q[$clog2(RATIO)-1:0]
  - state_q ∈ {IDLE, SHIFT}
  - cnt_q
- Signal definitions:
  - in_hs = s_axis_tvalid & s_axis_tready
  - out_hs = m_axis_tvalid & m_axis_tready
  - last = (idx_q == RATIO-1)
- s_axis_tready = (state_q == IDLE) | (out_hs & last). This is combinational from m_axis_tready; there is no other combinational input-to-output path.
- m_axis_tvalid = (state_q == SHIFT).
- m_axis_tdata = hold_q[idx_q*OUT_WIDTH +: OUT_WIDTH]. The word order is set by Configuration.
- IDLE:
  - in_hs loads hold_q, sets idx_q = 0, and moves to SHIFT.
- SHIFT:
  - out_hs & !last: idx_q increments.
  - out_hs & last & in_hs: reload hold_q, idx_q = 0, stay in SHIFT.
  - out_hs & last & !in_hs: go to IDLE, idx_q = 0.
  - No out_hs: hold_q, idx_q and the state are all frozen.
- cnt_q increments on every out_hs and wraps modulo 2^CNT_WIDTH.
- o_busy = (state_q == SHIFT).
- o_word_count = cnt_q.
- hold_q is not cleared on the return to IDLE. m_axis_tdata is don't-care while m_axis_tvalid = 0.

## Timing

- Reset values: state IDLE, idx_q 0, hold_q 0, cnt_q 0. The outputs follow:
  - s_axis_tready 1
  - m_axis_tvalid 0
  - m_axis_tdata 0
  - o_busy 0
  - o_word_count 0
- Latency: a beat accepted on edge N drives its first narrow word valid from edge N (visible in cycle N+1).
- Throughput: with s_axis_tvalid and m_axis_tready held high, one narrow word per cycle and one wide beat every RATIO cycles.
- AXIS rules:
  - Once m_axis_tvalid is high, m_axis_tvalid and m_axis_tdata stay stable until out_hs.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
- Reset mid-operation: the held beat is discarded and any unsent sub-words are lost. The block is back in the reset state on the next cycle, with cnt_q = 0.
- Simultaneous reset and handshake: reset wins, and no load or count takes place.

## Configuration

- Macro AXIS_DWC_MSB_FIRST_EN.
- Undefined: words are emitted LSB-first, slice index idx_q.
- Defined: words are emitted MSB-first, slice index RATIO-1-idx_q.
- All handshake, state and counter behaviour is identical in both builds.

## Test plan

- Reset, then a single beat 0x0004_0003_0002_0001 with m_axis_tready = 1:
  - Default build: words 0x0001, 0x0002, 0x0003, 0x0004 on 4 consecutive cycles.
  - Then m_axis_tvalid = 0, o_busy = 0, o_word_count = 4.
- Same beat, build with AXIS_DWC_MSB_FIRST_EN defined: words 0x0004, 0x0003, 0x0002, 0x0001.
- Back-to-back beats 0x...A3A2A1A0 and 0x...B3B2B1B0, both sinks always ready:
  - 8 words on 8 consecutive cycles with no gap.
  - s_axis_tready is high in the cycle of word A3's handshake.
- m_axis_tready low for 3 cycles after the 2nd word: m_axis_tdata held at 0x0002, m_axis_tvalid held at 1, s_axis_tready = 0, and the count frozen at 2.
- Assert m_axi_areset for 1 cycle after 2 words of a beat:
  - Next cycle m_axis_tvalid = 0, s_axis_tready = 1, o_word_count = 0.
  - A new beat then starts at word 0.
- With CNT_WIDTH = 4, send 5 beats (20 words): o_word_count = 4 after the wrap.
